// File: rtl/encrypt_tx_buf_cntrl_if.sv
// Byte-stream handshake between the TX DMA / encryption engine and the
// encryption TX buffer controller. The master side drives frame control,
// push and pop; the slave side (the controller) returns RAM addressing
// and buffer status.
interface encrypt_tx_buf_cntrl_if #(
    parameter int ADDR_WIDTH = 6
);
    logic                  txStart_p;
    logic [15:0]           txPayloadLen;
    logic                  txCCMP;
    logic                  pushDataInBuffer;
    logic                  popDataOutBuffer_p;
    logic                  encrTxBufFlush_p;

    logic                  writeEnEncrTxBuffer;
    logic [ADDR_WIDTH-1:0] writeAddrEncrTxBuffer;
    logic [ADDR_WIDTH-1:0] readAddrEncrTxBuffer;
    logic                  bufferFullFlag;
    logic                  bufferEmptyFlag;
    logic                  bufferAlmostEmptyFlag;
    logic                  micPhase;
    logic                  lastByteRead_p;
    logic                  txDone_p;
    logic                  overrunErr;

    modport master (
        output txStart_p, txPayloadLen, txCCMP, pushDataInBuffer,
               popDataOutBuffer_p, encrTxBufFlush_p,
        input  writeEnEncrTxBuffer, writeAddrEncrTxBuffer, readAddrEncrTxBuffer,
               bufferFullFlag, bufferEmptyFlag, bufferAlmostEmptyFlag,
               micPhase, lastByteRead_p, txDone_p, overrunErr
    );

    modport slave (
        input  txStart_p, txPayloadLen, txCCMP, pushDataInBuffer,
               popDataOutBuffer_p, encrTxBufFlush_p,
        output writeEnEncrTxBuffer, writeAddrEncrTxBuffer, readAddrEncrTxBuffer,
               bufferFullFlag, bufferEmptyFlag, bufferAlmostEmptyFlag,
               micPhase, lastByteRead_p, txDone_p, overrunErr
    );
endinterface

// File: rtl/encrypt_tx_buf_cntrl.sv
// Transmit-side circular plaintext buffer controller for the encryption path.
// DMA pushes payload bytes, the encryption engine pops them; each frame is
// bounded to the programmed payload length and CCMP frames are followed by
// an 8-pop MIC tail before txDone_p.
module encrypt_tx_buf_cntrl #(
    parameter int ADDR_WIDTH         = 6,
    parameter int BUF_SIZE           = 64,
    parameter int ALMOST_FULL_MARGIN = 4,
    parameter int ALMOST_EMPTY_LEVEL = 8
) (
    input  logic                   bbClk,
    input  logic                   hardRstBbClk_p,
    input  logic                   softRstBbClk_p,
    encrypt_tx_buf_cntrl_if.slave  bufIf
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        TAIL   = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [ADDR_WIDTH:0]   FULL_CNT  = (ADDR_WIDTH+1)'(BUF_SIZE);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE   = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(BUF_SIZE - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
    // Free space <= margin is equivalent to occupancy >= this threshold.
    localparam int                    FULL_THR  = BUF_SIZE - ALMOST_FULL_MARGIN;

    state_t                state;
    logic [15:0]           lenReg;
    logic                  ccmpReg;
    logic [15:0]           wrCnt;
    logic [15:0]           rdCnt;
    logic [2:0]            micCnt;
    logic [ADDR_WIDTH:0]   flagCnt;
    logic [ADDR_WIDTH-1:0] wrAddr;
    logic [ADDR_WIDTH-1:0] rdAddr;
    logic                  overrunReg;
    logic                  lastByteReg;

    logic                  wrEn;
    logic                  rdEn;
    logic                  finalRd;
    logic                  overrunPush;

    // Pointer advance with explicit wrap so non-power-of-2 depths work.
    function automatic logic [ADDR_WIDTH-1:0] nextAddr(input logic [ADDR_WIDTH-1:0] addr);
        return (addr == LAST_ADDR) ? '0 : addr + ADDR_ONE;
    endfunction

    assign wrEn        = bufIf.pushDataInBuffer & (state == ACTIVE) &
                         (flagCnt != FULL_CNT) & (wrCnt < lenReg);
    assign rdEn        = bufIf.popDataOutBuffer_p & (state == ACTIVE) & (flagCnt != '0);
    // len is non-zero whenever ACTIVE, so len-1 never underflows here.
    assign finalRd     = rdEn & (rdCnt == lenReg - 16'd1);
    assign overrunPush = bufIf.pushDataInBuffer & (state == ACTIVE) & (wrCnt >= lenReg);

    // Frame parameters are plain data, captured only when a frame is accepted.
    always_ff @(posedge bbClk) begin
        if ((state == IDLE) && bufIf.txStart_p) begin
            lenReg  <= bufIf.txPayloadLen;
            ccmpReg <= bufIf.txCCMP;
        end
    end

    // Frame FSM, pointers, occupancy and per-frame counters.
    always_ff @(posedge bbClk or posedge hardRstBbClk_p) begin
        if (hardRstBbClk_p) begin
            state       <= IDLE;
            wrCnt       <= '0;
            rdCnt       <= '0;
            micCnt      <= '0;
            flagCnt     <= '0;
            wrAddr      <= '0;
            rdAddr      <= '0;
            overrunReg  <= 1'b0;
            lastByteReg <= 1'b0;
        end else if (softRstBbClk_p || bufIf.encrTxBufFlush_p) begin
            // Abort without txDone_p; only a soft reset forgets the overrun.
            state       <= IDLE;
            wrCnt       <= '0;
            rdCnt       <= '0;
            micCnt      <= '0;
            flagCnt     <= '0;
            wrAddr      <= '0;
            rdAddr      <= '0;
            lastByteReg <= 1'b0;
            if (softRstBbClk_p) begin
                overrunReg <= 1'b0;
            end
        end else begin
            lastByteReg <= finalRd;
            if (overrunPush) begin
                overrunReg <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (bufIf.txStart_p) begin
                        wrCnt      <= '0;
                        rdCnt      <= '0;
                        micCnt     <= '0;
                        overrunReg <= 1'b0;
                        if (bufIf.txPayloadLen != 16'd0) begin
                            state <= ACTIVE;
                        end else if (bufIf.txCCMP) begin
                            state <= TAIL;
                        end else begin
                            state <= DONE;
                        end
                    end
                end
                ACTIVE: begin
                    if (finalRd) begin
                        state <= ccmpReg ? TAIL : DONE;
                    end
                end
                TAIL: begin
                    // MIC pops are counted only; the buffer is left untouched.
                    if (bufIf.popDataOutBuffer_p) begin
                        micCnt <= micCnt + 3'd1;
                        if (micCnt == 3'd7) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            if (wrEn) begin
                wrCnt  <= wrCnt + 16'd1;
                wrAddr <= nextAddr(wrAddr);
            end
            if (rdEn) begin
                rdCnt  <= rdCnt + 16'd1;
                rdAddr <= nextAddr(rdAddr);
            end

            case ({wrEn, rdEn})
                2'b10:   flagCnt <= flagCnt + CNT_ONE;
                2'b01:   flagCnt <= flagCnt - CNT_ONE;
                default: flagCnt <= flagCnt;
            endcase
        end
    end

    assign bufIf.writeEnEncrTxBuffer   = wrEn;
    assign bufIf.writeAddrEncrTxBuffer = wrAddr;
    assign bufIf.readAddrEncrTxBuffer  = rdAddr;
    assign bufIf.bufferEmptyFlag       = (flagCnt == '0);
    assign bufIf.bufferFullFlag        = (FULL_THR <= 0) || (int'(flagCnt) >= FULL_THR);
    // Low-level warning is meaningless once every payload byte has arrived.
    assign bufIf.bufferAlmostEmptyFlag = (int'(flagCnt) <= ALMOST_EMPTY_LEVEL) &&
                                         (wrCnt < lenReg) && (state == ACTIVE);
    assign bufIf.micPhase              = (state == TAIL);
    assign bufIf.txDone_p              = (state == DONE);
    assign bufIf.lastByteRead_p        = lastByteReg;
    assign bufIf.overrunErr            = overrunReg;

endmodule
